fifo_stream_reader: RTL and testbench

Drains a synchronous FIFO through its `ren`/`empty`/`dout` read port and presents the words as a valid/ready stream. It sits on the read side of `fifo_cnt`-style buffers, opposite the writer.
- Hides the FIFO read latency: one cycle in "Standard" mode, zero in "FWFT".
- Uses a 2-entry output buffer so that back-pressure never loses a word and sustained throughput is one word per cycle.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_skid_buf.sv | 67 ++++++
 rtl/fifo_stream_reader.sv | 89 ++++++++
 tb/tb_fifo_stream_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : FIFO read-mode names and mode decoding shared by FIFO-side blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam string MODE_STANDARD = "Standard";
    localparam string MODE_FWFT     = "FWFT";

    // Anything that is not exactly "FWFT" decodes as Standard.
    function automatic bit is_fwft(input string mode);
        return (mode == MODE_FWFT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_skid_buf.sv
// ============================================================================
// Module   : fifo_skid_buf
// Brief    : Two-entry ordered buffer; head is always entry 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] r_mem_q [2];
    logic [DATA_WIDTH-1:0] w_mem_d [2];
    logic [1:0]            r_occ_q;
    logic [1:0]            w_occ_d;
    logic [1:0]            w_wr_idx;

    always_comb begin
        w_mem_d  = r_mem_q;
        w_wr_idx = r_occ_q - {1'b0, pop};
        w_occ_d  = r_occ_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            w_mem_d[0] = r_mem_q[1];
        end
        // The write slot is taken after the shift, so push+pop lands behind the new head.
        if (push) begin
            if (w_wr_idx == 2'd0) begin
                w_mem_d[0] = push_data;
            end else begin
                w_mem_d[1] = push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_q[0] <= '0;
            r_mem_q[1] <= '0;
            r_occ_q    <= 2'd0;
        end else begin
            r_mem_q <= w_mem_d;
            r_occ_q <= w_occ_d;
        end
    end

    assign head = r_mem_q[0];
    assign occ  = r_occ_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (r_occ_q == 2'd2)));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (r_occ_q == 2'd0)));

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Drains a synchronous FIFO read port into a valid/ready stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter string MODE       = MODE_STANDARD,
    parameter int    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_ren,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    localparam bit C_FWFT = is_fwft(MODE);

    logic [1:0]           w_occ;
    logic                 w_pop;
    logic                 w_push;
    logic [2:0]           w_level;
    logic                 r_inflight_q;
    logic                 w_inflight_d;
    logic [CNT_WIDTH-1:0] r_xfer_cnt_q;
    logic [CNT_WIDTH-1:0] w_xfer_cnt_d;

    assign m_valid = (w_occ != 2'd0);
    assign w_pop   = m_valid & m_ready;

    // Words already committed to the buffer after this cycle's pop; a read is
    // only issued when its word is guaranteed a slot.
    assign w_level  = {1'b0, w_occ} + {2'b00, r_inflight_q} - {2'b00, w_pop};
    assign fifo_ren = !rst && !fifo_empty && (w_level <= 3'd1);

    generate
        if (C_FWFT) begin : g_fwft
            always_comb begin
                w_push       = fifo_ren;
                w_inflight_d = 1'b0;
            end
        end else begin : g_std
            always_comb begin
                w_push       = r_inflight_q;
                w_inflight_d = fifo_ren;
            end
        end
    endgenerate

    always_comb begin
        w_xfer_cnt_d = r_xfer_cnt_q + {{(CNT_WIDTH-1){1'b0}}, w_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight_q <= 1'b0;
            r_xfer_cnt_q <= '0;
        end else begin
            r_inflight_q <= w_inflight_d;
            r_xfer_cnt_q <= w_xfer_cnt_d;
        end
    end

    assign xfer_cnt = r_xfer_cnt_q;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (fifo_dout),
        .pop       (w_pop),
        .head      (m_data),
        .occ       (w_occ)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: three instances (Standard, FWFT, Standard with
// 4-bit counter), each fed by its own behavioural FIFO.
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [NI-1:0]  fifo_rst, fifo_empty, fifo_ren, m_valid, m_ready, wr_en;
    logic [DW-1:0]  fifo_dout [NI];
    logic [DW-1:0]  m_data    [NI];
    logic [DW-1:0]  wr_data   [NI];
    logic [15:0]    xfer_cnt0, xfer_cnt1;
    logic [3:0]     xfer_cnt2;

    // FIFO models: instance 1 is first-word-fall-through, the others registered-read.
    logic [DW-1:0]  mem [NI][2048];
    logic [10:0]    wp [NI];
    logic [10:0]    rp [NI];
    logic [DW-1:0]  dq [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (fifo_rst[i]) begin
                wp[i] <= '0;
                rp[i] <= '0;
                dq[i] <= '0;
            end else begin
                if (wr_en[i]) begin
                    mem[i][wp[i]] <= wr_data[i];
                    wp[i] <= wp[i] + 11'd1;
                end
                if (fifo_ren[i] && (wp[i] != rp[i])) begin
                    dq[i] <= mem[i][rp[i]];
                    rp[i] <= rp[i] + 11'd1;
                end
            end
        end
    end

    always @* begin
        for (int i = 0; i < NI; i++) begin
            fifo_empty[i] = (wp[i] == rp[i]);
            fifo_dout[i]  = (i == 1) ? mem[i][rp[i]] : dq[i];
        end
    end

    fifo_stream_reader #(.DATA_WIDTH(DW), .MODE("Standard"), .CNT_WIDTH(16)) u_dut_std (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]),
        .fifo_ren(fifo_ren[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .xfer_cnt(xfer_cnt0));

    fifo_stream_reader #(.DATA_WIDTH(DW), .MODE("FWFT"), .CNT_WIDTH(16)) u_dut_fwft (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]),
        .fifo_ren(fifo_ren[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .xfer_cnt(xfer_cnt1));

    fifo_stream_reader #(.DATA_WIDTH(DW), .MODE("Standard"), .CNT_WIDTH(4)) u_dut_cnt4 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty[2]), .fifo_dout(fifo_dout[2]),
        .fifo_ren(fifo_ren[2]), .m_data(m_data[2]), .m_valid(m_valid[2]),
        .m_ready(m_ready[2]), .xfer_cnt(xfer_cnt2));

    int checks = 0;
    int passed = 0;
    int ren_empty_viol = 0;

    logic [DW-1:0] exp_q [$];
    logic          cyc_valid [64];
    logic [DW-1:0] cyc_data  [64];
    logic          cyc_ren   [64];

    function automatic logic [15:0] get_xfer(input int inst);
        case (inst)
            0:       return xfer_cnt0;
            1:       return xfer_cnt1;
            default: return {12'd0, xfer_cnt2};
        endcase
    endfunction

    // Holds all DUTs in reset, clears one FIFO and loads exp_q into it.
    task automatic preload(input int inst);
        rst = 1'b1;
        m_ready = '0;
        fifo_rst[inst] = 1'b1;
        @(negedge clk);
        fifo_rst[inst] = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            wr_en[inst] = 1'b1;
            wr_data[inst] = exp_q[k];
            @(negedge clk);
        end
        wr_en[inst] = 1'b0;
    endtask

    // Cycle 0 is the current cycle; m_ready is driven high from cycle rdy_from on.
    task automatic run_cycles(input int inst, input int n, input int rdy_from);
        for (int c = 0; c < n; c++) begin
            m_ready[inst] = (c >= rdy_from);
            #1;
            cyc_valid[c] = m_valid[inst];
            cyc_data[c]  = m_data[inst];
            cyc_ren[c]   = fifo_ren[inst];
            if (fifo_ren[inst] && fifo_empty[inst]) ren_empty_viol++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fifo_rst = '1;
        wr_en = '0;
        m_ready = '0;
        for (int i = 0; i < NI; i++) wr_data[i] = '0;
        repeat (3) @(negedge clk);
        fifo_rst = '0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (m_valid[i] !== 1'b0 || fifo_ren[i] !== 1'b0 || m_data[i] !== '0 || get_xfer(i) !== 16'd0)
                $display("FAIL reset_state[%0d]: valid=%b ren=%b data=%h cnt=%0d want 0/0/0/0",
                         i, m_valid[i], fifo_ren[i], m_data[i], get_xfer(i));
            else passed++;
        end
        exp_q = '{32'hA5A5_0001, 32'hA5A5_0002};
        preload(0);
        #1;
        checks++;
        if (fifo_empty[0] !== 1'b0 || fifo_ren[0] !== 1'b0)
            $display("FAIL reset_ren_forced: empty=%b ren=%b want empty=0 ren=0", fifo_empty[0], fifo_ren[0]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_latency(input int inst, input int latency, input string name);
        int first;
        exp_q = '{32'h11, 32'h22, 32'h33};
        preload(inst);
        ren_empty_viol = 0;
        rst = 1'b0;
        run_cycles(inst, 8, 0);
        first = -1;
        for (int c = 0; c < 8; c++) if (cyc_valid[c] && first < 0) first = c;
        checks++;
        if (first != latency) $display("FAIL %s_first_valid: cycle %0d want %0d", name, first, latency);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cyc_valid[latency+k] !== 1'b1 || cyc_data[latency+k] !== exp_q[k])
                $display("FAIL %s_beat%0d: valid=%b data=%h want valid=1 data=%h",
                         name, k, cyc_valid[latency+k], cyc_data[latency+k], exp_q[k]);
            else passed++;
        end
        checks++;
        if (cyc_valid[latency+3] !== 1'b0) $display("FAIL %s_valid_drop: valid=%b want 0", name, cyc_valid[latency+3]);
        else passed++;
        checks++;
        if (get_xfer(inst) !== 16'd3) $display("FAIL %s_xfer_cnt: got %0d want 3", name, get_xfer(inst));
        else passed++;
        checks++;
        if (ren_empty_viol != 0) $display("FAIL %s_ren_while_empty: got %0d want 0", name, ren_empty_viol);
        else passed++;
    endtask

    task automatic test_back_pressure();
        int ren_stall;
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back($urandom);
        preload(0);
        rst = 1'b0;
        run_cycles(0, 20, 5);
        ren_stall = 0;
        for (int c = 0; c < 5; c++) if (cyc_ren[c]) ren_stall++;
        checks++;
        if (ren_stall != 2) $display("FAIL bp_stall_reads: got %0d want 2", ren_stall);
        else passed++;
        for (int c = 2; c < 5; c++) begin
            checks++;
            if (cyc_valid[c] !== 1'b1 || cyc_data[c] !== exp_q[0])
                $display("FAIL bp_hold_c%0d: valid=%b data=%h want valid=1 data=%h", c, cyc_valid[c], cyc_data[c], exp_q[0]);
            else passed++;
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cyc_valid[5+k] !== 1'b1 || cyc_data[5+k] !== exp_q[k])
                $display("FAIL bp_beat%0d: valid=%b data=%h want valid=1 data=%h", k, cyc_valid[5+k], cyc_data[5+k], exp_q[k]);
            else passed++;
        end
        checks++;
        if (cyc_valid[13] !== 1'b0 || xfer_cnt0 !== 16'd8)
            $display("FAIL bp_end: valid=%b cnt=%0d want valid=0 cnt=8", cyc_valid[13], xfer_cnt0);
        else passed++;
    endtask

    task automatic test_random(input int inst, input string name);
        int written, got, reads, pops, prev_ren, occ_est, model_viol, cyc, extra;
        logic [DW-1:0] w, e;
        exp_q.delete();
        preload(inst);
        rst = 1'b0;
        written = 0; got = 0; reads = 0; pops = 0; prev_ren = 0; model_viol = 0; cyc = 0;
        ren_empty_viol = 0;
        while (got < 1000 && cyc < 20000) begin
            wr_en[inst] = (written < 1000) && ($urandom_range(1, 0) == 1);
            if (wr_en[inst]) begin
                w = $urandom;
                wr_data[inst] = w;
                exp_q.push_back(w);
                written++;
            end
            m_ready[inst] = ($urandom_range(1, 0) == 1);
            #1;
            // Buffered words = reads completed so far minus beats taken.
            occ_est = reads - pops - ((inst == 1) ? 0 : prev_ren);
            if (occ_est > 2 || occ_est < 0 || m_valid[inst] !== (occ_est != 0)) model_viol++;
            if (fifo_ren[inst] && fifo_empty[inst]) ren_empty_viol++;
            if (m_valid[inst] && m_ready[inst]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s_extra_beat: data=%h want no beat", name, m_data[inst]);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data[inst] !== e) $display("FAIL %s_order beat %0d: data=%h want %h", name, got, m_data[inst], e);
                    else passed++;
                end
                got++;
                pops++;
            end
            prev_ren = fifo_ren[inst] ? 1 : 0;
            if (fifo_ren[inst]) reads++;
            cyc++;
            @(negedge clk);
        end
        wr_en[inst] = 1'b0;
        checks++;
        if (got != 1000) $display("FAIL %s_timeout: beats=%0d want 1000", name, got);
        else passed++;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            m_ready[inst] = 1'b1;
            #1;
            if (m_valid[inst]) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0 || exp_q.size() != 0 || get_xfer(inst) !== 16'd1000)
            $display("FAIL %s_no_dup: extra=%0d left=%0d cnt=%0d want 0/0/1000", name, extra, exp_q.size(), get_xfer(inst));
        else passed++;
        checks++;
        if (model_viol != 0) $display("FAIL %s_occupancy: violations=%0d want 0", name, model_viol);
        else passed++;
        checks++;
        if (ren_empty_viol != 0) $display("FAIL %s_ren_while_empty: got %0d want 0", name, ren_empty_viol);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        int nb;
        logic [DW-1:0] w;
        exp_q.delete();
        for (int k = 0; k < 6; k++) exp_q.push_back($urandom | 32'h1);
        preload(0);
        rst = 1'b0;
        run_cycles(0, 4, 0);
        checks++;
        if (cyc_ren[3] !== 1'b1 || xfer_cnt0 !== 16'd2)
            $display("FAIL rstmid_pre: ren=%b cnt=%0d want ren=1 cnt=2", cyc_ren[3], xfer_cnt0);
        else passed++;
        rst = 1'b1;
        fifo_rst[0] = 1'b1;
        m_ready[0] = 1'b1;
        #1;
        checks++;
        if (fifo_ren[0] !== 1'b0) $display("FAIL rstmid_ren_in_reset: got %b want 0", fifo_ren[0]);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        fifo_rst[0] = 1'b0;
        #1;
        checks++;
        if (m_valid[0] !== 1'b0 || m_data[0] !== '0 || xfer_cnt0 !== 16'd0 || fifo_ren[0] !== 1'b0)
            $display("FAIL rstmid_after: valid=%b data=%h cnt=%0d ren=%b want 0/0/0/0",
                     m_valid[0], m_data[0], xfer_cnt0, fifo_ren[0]);
        else passed++;
        exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            w = $urandom;
            wr_en[0] = 1'b1;
            wr_data[0] = w;
            exp_q.push_back(w);
            @(negedge clk);
        end
        wr_en[0] = 1'b0;
        run_cycles(0, 8, 0);
        nb = 0;
        for (int c = 0; c < 8; c++) begin
            if (cyc_valid[c]) begin
                checks++;
                if (nb >= 2) $display("FAIL rstmid_restart_extra: data=%h want no beat", cyc_data[c]);
                else if (cyc_data[c] !== exp_q[nb]) $display("FAIL rstmid_restart%0d: data=%h want %h", nb, cyc_data[c], exp_q[nb]);
                else passed++;
                nb++;
            end
        end
        checks++;
        if (nb != 2 || xfer_cnt0 !== 16'd2) $display("FAIL rstmid_restart_count: beats=%0d cnt=%0d want 2/2", nb, xfer_cnt0);
        else passed++;
    endtask

    task automatic test_cnt_wrap();
        int nb;
        exp_q.delete();
        for (int k = 0; k < 17; k++) exp_q.push_back($urandom);
        preload(2);
        rst = 1'b0;
        run_cycles(2, 30, 0);
        nb = 0;
        for (int c = 0; c < 30; c++) if (cyc_valid[c]) nb++;
        checks++;
        if (nb != 17) $display("FAIL wrap_beats: got %0d want 17", nb);
        else passed++;
        checks++;
        if (xfer_cnt2 !== 4'(17 % 16)) $display("FAIL wrap_cnt: got %0d want %0d", xfer_cnt2, 17 % 16);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_latency(0, 2, "std");
        test_latency(1, 1, "fwft");
        test_back_pressure();
        test_random(0, "rand_std");
        test_random(1, "rand_fwft");
        test_reset_mid_op();
        test_cnt_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
